pipeline_stall_controller: RTL and testbench

//   Central hazard/sequencing unit for the 5-stage RV32IM pipeline. Drives the stall,

---
 rtl/pipeline_stall_controller.sv | 111 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Hazard and sequencing unit for the 5-stage pipeline: stalls, flushes and bubbles for
// load-use, taken branches, multi-cycle MUL/DIV in EX and data-memory wait states.
module pipeline_stall_controller #(
   parameter int MUL_LATENCY = 2,
   parameter int DIV_LATENCY = 32,
   parameter int CNT_W       = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_dest_addr,
   input  logic        ex_mem_read,
   input  logic        ex_muldiv_start,
   input  logic        ex_muldiv_is_div,
   input  logic        ex_branch_taken,
   input  logic        dmem_busy,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        if_id_flush,
   output logic        id_ex_stall,
   output logic        id_ex_flush,
   output logic        ex_mem_stall,
   output logic        mem_wb_bubble,
   output logic        muldiv_busy,
   output logic        muldiv_done,
   output logic [31:0] stall_count
);

   typedef enum logic {IDLE = 1'b0, MULDIV = 1'b1} state_t;

   // The start cycle itself is one of the LAT cycles, so the counter loads LAT-1.
   localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LATENCY - 1);
   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             load_use;

   assign load_use = ex_mem_read && (ex_dest_addr != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1_addr == ex_dest_addr)) ||
                      (id_uses_rs2 && (id_rs2_addr == ex_dest_addr)));

   assign muldiv_busy = (state == MULDIV);

   always_comb begin
      pc_stall      = 1'b0;
      if_id_stall   = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_stall   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_stall  = 1'b0;
      mem_wb_bubble = 1'b0;
      muldiv_done   = 1'b0;
      state_nxt     = state;
      cnt_nxt       = cnt;
      if (!reset) begin
         if (dmem_busy) begin
            // Memory wait freezes everything upstream; an M-op keeps its count.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
         end else if (state == MULDIV) begin
            if (cnt != CNT_ONE) begin
               pc_stall     = 1'b1;
               if_id_stall  = 1'b1;
               id_ex_stall  = 1'b1;
               ex_mem_stall = 1'b1;
               cnt_nxt      = cnt - CNT_ONE;
            end else begin
               muldiv_done = 1'b1;
               state_nxt   = IDLE;
               cnt_nxt     = '0;
            end
         end else if (ex_muldiv_start) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            state_nxt    = MULDIV;
            cnt_nxt      = ex_muldiv_is_div ? DIV_INIT : MUL_INIT;
         end else if (ex_branch_taken) begin
            // ID is flushed, so any simultaneous load-use hazard is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         stall_count <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (pc_stall) stall_count <= stall_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed hazard scenarios plus random traffic,
// all checked cycle by cycle against an occupancy-based model of the pipeline.
module tb_pipeline_stall_controller;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_dest_addr;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read;
   logic        ex_muldiv_start, ex_muldiv_is_div, ex_branch_taken, dmem_busy;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic        ex_mem_stall, mem_wb_bubble, muldiv_busy, muldiv_done;
   logic [31:0] stall_count;

   int          checks = 0;
   int          failures = 0;
   int          progress = 0;
   int          op_lat = 0;
   logic [31:0] m_stall_cnt = 32'd0;
   logic        last_done, last_pc;

   pipeline_stall_controller #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_W(6)) dut (
      .clk(clk), .reset(reset),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_dest_addr(ex_dest_addr), .ex_mem_read(ex_mem_read),
      .ex_muldiv_start(ex_muldiv_start), .ex_muldiv_is_div(ex_muldiv_is_div),
      .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
      .mem_wb_bubble(mem_wb_bubble), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_in();
      reset = 1'b0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_dest_addr = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_muldiv_start = 1'b0; ex_muldiv_is_div = 1'b0; ex_branch_taken = 1'b0;
      dmem_busy = 1'b0;
   endtask

   // Model: an M-op in EX needs LAT cycles of progress; memory-wait cycles make none.
   task automatic run_cycle();
      logic e_pc, e_ifs, e_ifl, e_ids, e_idf, e_exs, e_bub, e_done, hazard, op_here;
      int   lat_now;
      @(negedge clk);
      {e_pc, e_ifs, e_ifl, e_ids, e_idf, e_exs, e_bub, e_done} = 8'd0;
      hazard  = ex_mem_read && (ex_dest_addr != 0) &&
                ((id_uses_rs1 && id_rs1_addr == ex_dest_addr) ||
                 (id_uses_rs2 && id_rs2_addr == ex_dest_addr));
      lat_now = (progress > 0) ? op_lat : (ex_muldiv_is_div ? DIV_LAT : MUL_LAT);
      op_here = (progress > 0) || ex_muldiv_start;
      if (reset) begin
      end else if (dmem_busy) begin
         {e_pc, e_ifs, e_ids, e_exs, e_bub} = 5'b11111;
      end else if (op_here) begin
         if (progress == lat_now - 1) e_done = 1'b1;
         else {e_pc, e_ifs, e_ids, e_exs} = 4'b1111;
      end else if (ex_branch_taken) begin
         {e_ifl, e_idf} = 2'b11;
      end else if (hazard) begin
         {e_pc, e_ifs, e_idf} = 3'b111;
      end
      check("pc_stall", 32'(pc_stall), 32'(e_pc));
      check("if_id_stall", 32'(if_id_stall), 32'(e_ifs));
      check("if_id_flush", 32'(if_id_flush), 32'(e_ifl));
      check("id_ex_stall", 32'(id_ex_stall), 32'(e_ids));
      check("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
      check("ex_mem_stall", 32'(ex_mem_stall), 32'(e_exs));
      check("mem_wb_bubble", 32'(mem_wb_bubble), 32'(e_bub));
      check("muldiv_done", 32'(muldiv_done), 32'(e_done));
      check("muldiv_busy", 32'(muldiv_busy), 32'(progress > 0));
      check("stall_count", stall_count, m_stall_cnt);
      last_done = muldiv_done;
      last_pc   = pc_stall;
      @(posedge clk);
      if (reset) begin
         progress    = 0;
         m_stall_cnt = 32'd0;
      end else begin
         if (e_pc) m_stall_cnt = m_stall_cnt + 32'd1;
         if (!dmem_busy && op_here) begin
            if (e_done) progress = 0;
            else begin
               if (progress == 0) op_lat = lat_now;
               progress++;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1'b1;
      run_cycle();
      run_cycle();
      reset = 1'b0;
   endtask

   task automatic hold_mop(input logic is_div, input int n);
      ex_muldiv_start  = 1'b1;
      ex_muldiv_is_div = is_div;
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   initial begin
      clear_in();
      do_reset();
      check("reset_stall_count", stall_count, 32'd0);
      check("reset_busy", 32'(muldiv_busy), 32'd0);

      // Load x5 in EX, ID reads rs2=x5: one stall cycle, then the load has moved on.
      ex_mem_read = 1'b1; ex_dest_addr = 5'd5; id_uses_rs2 = 1'b1; id_rs2_addr = 5'd5;
      run_cycle();
      check("lu_stall", 32'(last_pc), 32'd1);
      ex_mem_read = 1'b0;
      run_cycle();
      check("lu_release", 32'(last_pc), 32'd0);
      ex_mem_read = 1'b1; ex_dest_addr = 5'd0; id_rs2_addr = 5'd0;
      run_cycle();
      check("lu_x0", 32'(last_pc), 32'd0);

      // Taken branch coinciding with a load-use hazard.
      ex_dest_addr = 5'd7; id_uses_rs1 = 1'b1; id_rs1_addr = 5'd7; ex_branch_taken = 1'b1;
      run_cycle();
      check("br_lu_pc", 32'(last_pc), 32'd0);
      clear_in();

      // DIV: 31 stall cycles then done.
      do_reset();
      hold_mop(1'b1, DIV_LAT);
      check("div_done", 32'(last_done), 32'd1);
      check("div_stall_count", stall_count, 32'd31);
      clear_in();
      run_cycle();

      // MUL followed directly by another MUL.
      hold_mop(1'b0, MUL_LAT);
      check("mul1_done", 32'(last_done), 32'd1);
      hold_mop(1'b0, 1);
      check("mul2_stall", 32'(last_pc), 32'd1);
      hold_mop(1'b0, 1);
      check("mul2_done", 32'(last_done), 32'd1);
      clear_in();

      // Memory wait landing on the final DIV cycle delays done by three cycles.
      do_reset();
      hold_mop(1'b1, DIV_LAT - 1);
      dmem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         check("dmem_no_done", 32'(last_done), 32'd0);
      end
      dmem_busy = 1'b0;
      run_cycle();
      check("dmem_late_done", 32'(last_done), 32'd1);
      clear_in();

      // Reset in the middle of a DIV aborts it.
      do_reset();
      hold_mop(1'b1, 22);
      reset = 1'b1;
      run_cycle();
      reset = 1'b0; ex_muldiv_start = 1'b0;
      run_cycle();
      check("abort_busy", 32'(muldiv_busy), 32'd0);
      check("abort_done", 32'(last_done), 32'd0);
      check("abort_count", stall_count, 32'd0);

      // Random traffic; an M-op is kept presented in EX until its done cycle.
      for (int n = 0; n < 3000; n++) begin
         id_rs1_addr  = 5'($urandom_range(0, 3));
         id_rs2_addr  = 5'($urandom_range(0, 3));
         ex_dest_addr = 5'($urandom_range(0, 3));
         id_uses_rs1  = 1'($urandom_range(0, 1));
         id_uses_rs2  = 1'($urandom_range(0, 1));
         dmem_busy    = ($urandom_range(0, 4) == 0);
         reset        = ($urandom_range(0, 299) == 0);
         if (progress > 0) begin
            ex_muldiv_start  = 1'b1;
            ex_muldiv_is_div = (op_lat == DIV_LAT);
            ex_branch_taken  = 1'b0;
            ex_mem_read      = 1'b0;
         end else begin
            ex_muldiv_start  = ($urandom_range(0, 9) < 2);
            ex_muldiv_is_div = ($urandom_range(0, 3) == 0);
            ex_branch_taken  = !ex_muldiv_start && ($urandom_range(0, 5) == 0);
            ex_mem_read      = !ex_muldiv_start && ($urandom_range(0, 2) == 0);
         end
         run_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
